// File: rtl/usbdev_resume_tx.sv
// Remote-wakeup transmitter: waits for a J-idle bus, drives K for DriveKUs, then releases the bus.
// Host-response tracking (WaitHost) is compiled in only with USBDEV_RESUME_TX_HOST_CHECK_EN.

module usbdev_resume_tx #(
  parameter int unsigned IdleWaitUs    = 5000,
  parameter int unsigned DriveKUs      = 2000,
  parameter int unsigned HostTimeoutUs = 30000,
  parameter int unsigned CntW          = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic us_tick_i,
  input  logic suspended_i,
  input  logic resume_req_i,
  input  logic pinflip_i,
  input  logic rx_dp_i,
  input  logic rx_dn_i,
  output logic tx_oe_o,
  output logic tx_dp_o,
  output logic tx_dn_o,
  output logic busy_o,
  output logic done_o,
  output logic aborted_o,
  output logic timeout_o
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSettle   = 3'd1;
  localparam logic [2:0] StDriveK   = 3'd2;
  localparam logic [2:0] StRelease  = 3'd3;
`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
  localparam logic [2:0] StWaitHost = 3'd4;
  localparam logic [CntW-1:0] HostToCnt = CntW'(HostTimeoutUs);
`endif

  localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};
  localparam logic [CntW-1:0] IdleWaitCnt = CntW'(IdleWaitUs);
  localparam logic [CntW-1:0] DriveKCnt   = CntW'(DriveKUs);

  if ((64'(IdleWaitUs) >= (64'd1 << CntW)) || (64'(DriveKUs) >= (64'd1 << CntW)) ||
      (64'(HostTimeoutUs) >= (64'd1 << CntW))) begin : g_bad_cnt_w
    $error("usbdev_resume_tx: a *Us parameter does not fit in CntW bits");
  end
  if (DriveKUs < 1000 || DriveKUs > 15000) begin : g_bad_drive_k
    $error("usbdev_resume_tx: DriveKUs outside 1000..15000");
  end

  logic [2:0]      st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            done_d, abort_d;
  logic            line_dp, line_dn, line_j, line_se0;

  // Undo the D+/D- swap so the FSM always reasons in unflipped J/K terms.
  assign line_dp  = pinflip_i ? rx_dn_i : rx_dp_i;
  assign line_dn  = pinflip_i ? rx_dp_i : rx_dn_i;
  assign line_j   = line_dp & ~line_dn;
  assign line_se0 = ~line_dp & ~line_dn;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
  logic line_k, tmo_d;
  logic k_seen_q, k_seen_d, se0_seen_q, se0_seen_d;
  assign line_k = ~line_dp & line_dn;
`else
  logic done_pend_q, done_pend_d;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    k_seen_d   = k_seen_q;
    se0_seen_d = se0_seen_q;
`else
    done_d      = done_pend_q;
    done_pend_d = 1'b0;
`endif
    case (st_q)
      StIdle: begin
        if (resume_req_i) begin
          if (suspended_i) begin
            st_d  = StSettle;
            cnt_d = '0;
          end else begin
            abort_d = 1'b1;
          end
        end
      end
      StSettle: begin
        if (!suspended_i || line_se0) begin
          st_d    = StIdle;
          abort_d = 1'b1;
        end else if (!line_j) begin
          cnt_d = '0;
        end else if (us_tick_i) begin
          if (cnt_inc == IdleWaitCnt) begin
            st_d  = StDriveK;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDriveK: begin
        if (!suspended_i) begin
          st_d    = StIdle;
          abort_d = 1'b1;
        end else if (us_tick_i) begin
          if (cnt_inc == DriveKCnt) begin
            st_d  = StRelease;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StRelease: begin
`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
        st_d       = StWaitHost;
        cnt_d      = '0;
        k_seen_d   = 1'b0;
        se0_seen_d = 1'b0;
`else
        // done_o follows one cycle after returning to Idle
        st_d        = StIdle;
        done_pend_d = 1'b1;
`endif
      end
`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
      StWaitHost: begin
        if (!suspended_i) begin
          st_d    = StIdle;
          done_d  = se0_seen_q;
          abort_d = ~se0_seen_q;
        end else if (se0_seen_q && line_j) begin
          st_d   = StIdle;
          done_d = 1'b1;
        end else if (us_tick_i && cnt_inc == HostToCnt) begin
          st_d  = StIdle;
          tmo_d = 1'b1;
        end else begin
          if (us_tick_i) cnt_d = cnt_inc;
          if (line_k) k_seen_d = 1'b1;
          if (line_se0 && k_seen_q) se0_seen_d = 1'b1;
        end
      end
`endif
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q      <= StIdle;
      cnt_q     <= '0;
      tx_oe_o   <= 1'b0;
      tx_dp_o   <= 1'b0;
      tx_dn_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      aborted_o <= 1'b0;
`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
      timeout_o  <= 1'b0;
      k_seen_q   <= 1'b0;
      se0_seen_q <= 1'b0;
`else
      done_pend_q <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      tx_oe_o   <= (st_d == StDriveK);
      tx_dp_o   <= (st_d == StDriveK) & pinflip_i;
      tx_dn_o   <= (st_d == StDriveK) & ~pinflip_i;
      busy_o    <= (st_d != StIdle);
      done_o    <= done_d;
      aborted_o <= abort_d;
`ifdef USBDEV_RESUME_TX_HOST_CHECK_EN
      timeout_o  <= tmo_d;
      k_seen_q   <= k_seen_d;
      se0_seen_q <= se0_seen_d;
`else
      done_pend_q <= done_pend_d;
`endif
    end
  end

endmodule
